// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: config registers, enable sequencing and receive FIFO
// for a single uart_rx instance, with host register port and interrupt.
module uart_rx_ctrl #(
   parameter int FIFO_DEPTH    = 16,
   parameter int TIMEOUT_TICKS = 40
) (
   input  logic        clk,
   input  logic        rstn_i,
   input  logic        cfg_we_i,
   input  logic        cfg_re_i,
   input  logic [1:0]  cfg_addr_i,
   input  logic [31:0] cfg_wdata_i,
   output logic [31:0] cfg_rdata_o,
   output logic        rx_enable_o,
   output logic [31:0] clk_div_o,
   output logic        parity_en_o,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   input  logic        rx_err_i,
   output logic        irq_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);

   localparam logic [1:0] S_OFF   = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_REARM = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          enable_q, parity_q;
   logic          thr_en_q, tmo_en_q, ovf_en_q;
   logic [7:0]    thr_q;
   logic [31:0]   clkdiv_q;

   logic [8:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q;

   logic          ovf_q, perr_q, tmo_q;
   logic [31:0]   baud_q;
   logic [TW-1:0] tick_q;
   logic          irq_q;
   logic [31:0]   rdata_q;
   logic [31:0]   rd_mux;

   logic ctrl_wr, clkdiv_wr, status_wr;
   logic flush, empty, full;
   logic push_req, push_ok, pop, ovf_set;
   logic run, baud_tick, tick_clr, tmo_set;
   logic irq_d;

   // Decode strobes and FIFO/timeout qualifiers; flush beats push and pop.
   always_comb begin
      ctrl_wr   = cfg_we_i && (cfg_addr_i == 2'd0);
      clkdiv_wr = cfg_we_i && (cfg_addr_i == 2'd1);
      status_wr = cfg_we_i && (cfg_addr_i == 2'd2);
      flush     = ctrl_wr && cfg_wdata_i[2];
      empty     = (count_q == '0);
      full      = (count_q == CW'(FIFO_DEPTH));
      push_req  = rx_valid_i && (state_q != S_OFF);
      pop       = cfg_re_i && (cfg_addr_i == 2'd3)
                  && !empty && !flush;
      push_ok   = push_req && !flush && (!full || pop);
      ovf_set   = push_req && !flush && full && !pop;
      run       = (state_q == S_RUN);
      baud_tick = run && (baud_q == clkdiv_q);
      tick_clr  = push_ok || pop || flush || empty;
      tmo_set   = !tick_clr && baud_tick
                  && (tick_q == TW'(TIMEOUT_TICKS - 1));
      irq_d     = (thr_en_q && (8'(count_q) >= thr_q)
                   && (thr_q != 8'd0))
                  || (tmo_en_q && tmo_q)
                  || (ovf_en_q && ovf_q);
   end

   // Next FSM state; any config change while running forces a 1-cycle rearm.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_OFF: begin
            if (ctrl_wr && cfg_wdata_i[0])
               state_d = S_RUN;
         end
         S_RUN: begin
            if (ctrl_wr && !cfg_wdata_i[0])
               state_d = S_OFF;
            else if (clkdiv_wr
                     || (ctrl_wr && (cfg_wdata_i[1] != parity_q)))
               state_d = S_REARM;
         end
         S_REARM: begin
            if (ctrl_wr && !cfg_wdata_i[0])
               state_d = S_OFF;
            else
               state_d = S_RUN;
         end
         default: state_d = S_OFF;
      endcase
   end

   // Register read mux; a DATA read of an empty or flushed FIFO yields 0.
   always_comb begin
      rd_mux = '0;
      case (cfg_addr_i)
         2'd0: rd_mux = {16'b0, thr_q, 2'b0, ovf_en_q, tmo_en_q,
                         thr_en_q, 1'b0, parity_q, enable_q};
         2'd1: rd_mux = clkdiv_q;
         2'd2: rd_mux = {16'b0, 8'(count_q), 4'b0,
                         tmo_q, perr_q, ovf_q, !empty};
         default: rd_mux = pop ? {1'b1, 22'b0, mem[rptr_q]} : '0;
      endcase
   end

   // FSM state and configuration registers.
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= S_OFF;
         enable_q <= 1'b0;
         parity_q <= 1'b0;
         thr_en_q <= 1'b0;
         tmo_en_q <= 1'b0;
         ovf_en_q <= 1'b0;
         thr_q    <= '0;
         clkdiv_q <= '0;
      end else begin
         state_q <= state_d;
         if (ctrl_wr) begin
            enable_q <= cfg_wdata_i[0];
            parity_q <= cfg_wdata_i[1];
            thr_en_q <= cfg_wdata_i[3];
            tmo_en_q <= cfg_wdata_i[4];
            ovf_en_q <= cfg_wdata_i[5];
            thr_q    <= cfg_wdata_i[15:8];
         end
         if (clkdiv_wr)
            clkdiv_q <= cfg_wdata_i;
      end
   end

   // FIFO storage; contents need no reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wptr_q] <= {rx_err_i, rx_data_i};
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok)
            wptr_q <= wptr_q + 1'b1;
         if (pop)
            rptr_q <= rptr_q + 1'b1;
         count_q <= count_q + CW'(push_ok) - CW'(pop);
      end
   end

   // Sticky status flags: write-1-to-clear, a same-cycle set wins.
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         ovf_q  <= 1'b0;
         perr_q <= 1'b0;
         tmo_q  <= 1'b0;
      end else begin
         ovf_q  <= (ovf_q && !(status_wr && cfg_wdata_i[1]))
                   || ovf_set;
         perr_q <= (perr_q && !(status_wr && cfg_wdata_i[2]))
                   || (push_req && rx_err_i);
         tmo_q  <= (tmo_q && !(status_wr && cfg_wdata_i[3]))
                   || tmo_set;
      end
   end

   // Baud divider and idle tick counter, the latter saturating at the limit.
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         baud_q <= '0;
         tick_q <= '0;
      end else begin
         if (!run || baud_tick)
            baud_q <= '0;
         else
            baud_q <= baud_q + 32'd1;
         if (tick_clr)
            tick_q <= '0;
         else if (baud_tick && (tick_q != TW'(TIMEOUT_TICKS)))
            tick_q <= tick_q + 1'b1;
      end
   end

   // Registered read data and interrupt.
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         rdata_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         if (cfg_re_i)
            rdata_q <= rd_mux;
         irq_q <= irq_d;
      end
   end

   assign cfg_rdata_o = rdata_q;
   assign rx_enable_o = run;
   assign clk_div_o   = clkdiv_q;
   assign parity_en_o = parity_q;
   assign irq_o       = irq_q;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller that configures and sequences one uart_rx instance and buffers its output. It holds the config registers (enable, parity, clock divider) and drives uart_rx enable/config. Received bytes and their parity-error flags go into a FIFO, which a host drains through a small register port. An interrupt is raised on fill threshold, character timeout or overflow.

Parameters:
FIFO_DEPTH, 16, number of entries; power of 2, ≥2.
TIMEOUT_TICKS, 40, baud ticks with no push/pop and a non-empty FIFO before the timeout flag sets (40 = 4 chars at 10 bits).

Ports:
clk  in  1  clock
rstn_i  in  1  asynchronous active-low reset
cfg_we_i  in  1  register write strobe
cfg_re_i  in  1  register read strobe
cfg_addr_i  in  2  register address
cfg_wdata_i  in  32  write data
cfg_rdata_o  out  32  read data, registered
rx_enable_o  out  1  to uart_rx rx_enable_i
clk_div_o  out  32  to uart_rx clk_div_i
parity_en_o  out  1  to uart_rx parity_en_i
rx_data_i  in  8  from uart_rx rx_data_o
rx_valid_i  in  1  from uart_rx rx_valid_o, 1-cycle pulse
rx_err_i  in  1  from uart_rx rx_err_o
irq_o  out  1  level interrupt

Behaviour:
- Reset: ctrl=0, clkdiv=0, FIFO empty, sticky flags 0, timeout counter 0, FSM=OFF. Reset outputs: rx_enable_o=0, clk_div_o=0, parity_en_o=0, cfg_rdata_o=0, irq_o=0.
- Registers:
  - addr0 CTRL (R/W): [0] enable, [1] parity_en, [2] flush (write-only, self-clearing, reads 0), [3] thr_irq_en, [4] tmo_irq_en, [5] ovf_irq_en, [15:8] threshold.
  - addr1 CLKDIV (R/W, 32-bit).
  - addr2 STATUS: [0] not_empty, [1] overflow sticky, [2] parity_err sticky, [3] timeout, [15:8] count. A write of 1 to bits 1–3 clears them; bit 0 and count are read-only.
  - addr3 DATA (RO): {valid, 22'b0, err, data[7:0]}. cfg_re_i pops when non-empty; when empty it returns 0 and changes no state.
- Reads: cfg_rdata_o is updated the cycle after cfg_re_i and holds otherwise. The pop takes effect in the cycle cfg_re_i is sampled. Simultaneous we and re are both honoured.
- FSM states:
  - OFF: rx_enable_o=0. Go to RUN when CTRL.enable is written to 1.
  - RUN: rx_enable_o=1. On a CTRL.enable write of 0, go to OFF. On any write to CLKDIV, or to CTRL with a changed parity_en, go to REARM.
  - REARM: rx_enable_o=0 for exactly 1 cycle, then RUN. This re-synchronises uart_rx to the new config.
- clk_div_o and parity_en_o update the cycle after the write.
- Push: rx_valid_i while the FSM is not OFF writes {rx_err_i, rx_data_i}. rx_err_i=1 also sets sticky parity_err.
- Full FIFO:
  - Push without a simultaneous pop: the byte is dropped and overflow is set.
  - Push with a simultaneous pop: both occur, count unchanged, no overflow.
- Flush: clears the FIFO and the timeout counter. It wins over a same-cycle push (byte dropped, no overflow) and a same-cycle pop (read returns 0).
- Count:
  - Width is $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - Count saturates at FIFO_DEPTH.
  - Count is zero-extended into STATUS[15:8].
- Timeout:
  - An internal baud counter wraps every clkdiv+1 cycles and runs only in RUN.
  - The tick counter resets on push, pop, flush, or when the FIFO is empty.
  - The timeout flag sets when the tick count reaches TIMEOUT_TICKS and stays set until cleared by a STATUS write.
- irq_o (registered, 1-cycle latency) = (thr_irq_en & count≥threshold & threshold≠0) | (tmo_irq_en & timeout) | (ovf_irq_en & overflow).
- Reset mid-operation: all state returns to reset values immediately; FIFO contents are lost.

Test Plan:
- Write CLKDIV=867, CTRL=0x01 -> clk_div_o=867, rx_enable_o=1 one cycle after the CTRL write; FSM RUN.
- Push 0x55, 0xA3 (err=0), then read DATA twice -> 0x80000055, then 0x800000A3; a third read returns 0x0, count=0.
- With FIFO_DEPTH=16, push 17 bytes with no reads -> STATUS count=16, overflow=1, irq_o=1 if ovf_irq_en; the 17th byte is absent when drained.
- FIFO full, push and pop in the same cycle -> count stays 16, overflow stays 0, the popped byte is the oldest.
- In RUN, write CLKDIV=433 -> rx_enable_o low for exactly 1 cycle, then high; clk_div_o=433.
- clkdiv=9, tmo_irq_en=1, push one byte, then idle -> timeout sets after 40×10 cycles and irq_o asserts; a STATUS write of 0x8 clears it; flush empties the FIFO.
